// File: rtl/regfile_mp_if.sv
// Bus bundle for regfile_mp: read ports, write ports, allocation and status.
// Signal names keep the register file's own _i/_o direction suffixes.
interface regfile_mp_if #(
    parameter int unsigned XLEN = 32,
    parameter int unsigned NREG = 32,
    parameter int unsigned NRD  = 2,
    parameter int unsigned NWR  = 2
);
    localparam int unsigned AW = $clog2(NREG);

    logic [NRD*AW-1:0]   rd_id_i;
    logic [NRD*XLEN-1:0] rd_data_o;
    logic [NRD-1:0]      rd_busy_o;
    logic [NWR-1:0]      w_en_i;
    logic [NWR*AW-1:0]   w_id_i;
    logic [NWR*XLEN-1:0] w_data_i;
    logic                alloc_en_i;
    logic [AW-1:0]       alloc_id_i;
    logic                ready_o;
    logic [NREG-1:0]     busy_o;

    modport master (
        output rd_id_i, w_en_i, w_id_i, w_data_i, alloc_en_i, alloc_id_i,
        input  rd_data_o, rd_busy_o, ready_o, busy_o
    );

    modport slave (
        input  rd_id_i, w_en_i, w_id_i, w_data_i, alloc_en_i, alloc_id_i,
        output rd_data_o, rd_busy_o, ready_o, busy_o
    );
endinterface

// File: rtl/regfile_mp.sv
// Multi-port register file with write->read bypass, busy scoreboard and a
// post-reset clear sweep; register 0 is hardwired to zero.
module regfile_mp #(
    parameter int unsigned XLEN = 32,
    parameter int unsigned NREG = 32,
    parameter int unsigned NRD  = 2,
    parameter int unsigned NWR  = 2
) (
    input  logic         clk,
    input  logic         rst,
    regfile_mp_if.slave  bus
);
    localparam int unsigned AW = $clog2(NREG);

    typedef enum logic [0:0] {StClear, StRun} state_e;

    state_e          r_state;
    state_e          w_state_d;
    logic [AW-1:0]   r_ptr;
    logic [XLEN-1:0] r_rf [NREG];
    logic [NREG-1:0] r_busy;
    logic            w_run;
    logic            w_sweep_last;
    logic [AW-1:0]   w_rid;
    logic [XLEN-1:0] w_rdata;
    logic            w_pend;

    assign w_run        = (r_state == StRun);
    assign w_sweep_last = (r_ptr == AW'(NREG - 1));

    always_ff @(posedge clk) begin : state_reg
        if (rst) begin
            r_state <= StClear;
            r_ptr   <= '0;
        end else begin
            r_state <= w_state_d;
            if (r_state == StClear) begin
                r_ptr <= r_ptr + 1'b1;
            end
        end
    end

    always_comb begin : next_state
        w_state_d = r_state;
        unique case (r_state)
            StClear: if (w_sweep_last) w_state_d = StRun;
            StRun:   w_state_d = StRun;
        endcase
    end

    always_comb begin : status_out
        bus.ready_o = w_run;
        bus.busy_o  = r_busy;
    end

    // Loop order makes the highest-index write port win on an index collision.
    always_ff @(posedge clk) begin : rf_write
        if (!rst) begin
            if (!w_run) begin
                r_rf[r_ptr] <= '0;
            end else begin
                for (int j = 0; j < NWR; j++) begin
                    if (bus.w_en_i[j] && (bus.w_id_i[j*AW +: AW] != '0)) begin
                        r_rf[bus.w_id_i[j*AW +: AW]] <= bus.w_data_i[j*XLEN +: XLEN];
                    end
                end
            end
        end
    end

    // Alloc is applied after the write clears so a new producer keeps the reg busy.
    always_ff @(posedge clk) begin : scoreboard
        if (rst) begin
            r_busy <= '0;
        end else if (w_run) begin
            for (int j = 0; j < NWR; j++) begin
                if (bus.w_en_i[j] && (bus.w_id_i[j*AW +: AW] != '0)) begin
                    r_busy[bus.w_id_i[j*AW +: AW]] <= 1'b0;
                end
            end
            if (bus.alloc_en_i && (bus.alloc_id_i != '0)) begin
                r_busy[bus.alloc_id_i] <= 1'b1;
            end
        end
    end

    always_comb begin : read_ports
        bus.rd_data_o = '0;
        bus.rd_busy_o = '0;
        w_rid         = '0;
        w_rdata       = '0;
        w_pend        = 1'b0;
        for (int k = 0; k < NRD; k++) begin
            w_rid   = bus.rd_id_i[k*AW +: AW];
            w_rdata = r_rf[w_rid];
            w_pend  = r_busy[w_rid];
            for (int j = 0; j < NWR; j++) begin
                if (w_run && bus.w_en_i[j] && (bus.w_id_i[j*AW +: AW] == w_rid)) begin
                    w_rdata = bus.w_data_i[j*XLEN +: XLEN];
                    w_pend  = 1'b0;
                end
            end
            if (!w_run || (w_rid == '0)) begin
                w_rdata = '0;
                w_pend  = 1'b0;
            end
            bus.rd_data_o[k*XLEN +: XLEN] = w_rdata;
            bus.rd_busy_o[k]              = w_pend;
        end
    end
endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp: directed vector table, reset/sweep sequences
// and randomized traffic against an array-based reference model.
module tb_regfile_mp;
    localparam int unsigned XLEN = 32;
    localparam int unsigned NREG = 32;
    localparam int unsigned NRD  = 2;
    localparam int unsigned NWR  = 2;
    localparam int unsigned AW   = $clog2(NREG);

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    regfile_mp_if #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD), .NWR(NWR)) bus ();

    regfile_mp #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD), .NWR(NWR)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: architectural contents, busy set, sweep progress.
    logic [XLEN-1:0] m_rf [NREG];
    logic [NREG-1:0] m_busy;
    bit              m_ready;
    int              m_sweep;

    typedef struct {
        logic [1:0]      wen;
        logic [AW-1:0]   wid0;
        logic [XLEN-1:0] wd0;
        logic [AW-1:0]   wid1;
        logic [XLEN-1:0] wd1;
        logic            aen;
        logic [AW-1:0]   aid;
        logic [AW-1:0]   rid0;
        logic [AW-1:0]   rid1;
        logic [XLEN-1:0] exp_d0;
        logic [XLEN-1:0] exp_d1;
        logic [1:0]      exp_rb;
        logic [NREG-1:0] exp_busy;
    } vec_t;

    vec_t vecs [13];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic set_in(input logic [1:0] wen, input logic [AW-1:0] wid0,
                          input logic [XLEN-1:0] wd0, input logic [AW-1:0] wid1,
                          input logic [XLEN-1:0] wd1, input logic aen,
                          input logic [AW-1:0] aid, input logic [AW-1:0] rid0,
                          input logic [AW-1:0] rid1);
        bus.w_en_i     = wen;
        bus.w_id_i     = {wid1, wid0};
        bus.w_data_i   = {wd1, wd0};
        bus.alloc_en_i = aen;
        bus.alloc_id_i = aid;
        bus.rd_id_i    = {rid1, rid0};
    endtask

    task automatic set_idle(input logic [AW-1:0] rid0, input logic [AW-1:0] rid1);
        set_in(2'b00, '0, '0, '0, '0, 1'b0, '0, rid0, rid1);
    endtask

    // Model advance for one rising edge, using the inputs currently applied.
    task automatic model_edge();
        logic [AW-1:0] id;
        if (rst) begin
            m_ready = 1'b0;
            m_sweep = 0;
            m_busy  = '0;
        end else if (!m_ready) begin
            m_sweep++;
            if (m_sweep == NREG) begin
                m_ready = 1'b1;
                for (int i = 0; i < NREG; i++) m_rf[i] = '0;
            end
        end else begin
            for (int j = 0; j < NWR; j++) begin
                id = bus.w_id_i[j*AW +: AW];
                if (bus.w_en_i[j] && id != 0) begin
                    m_rf[id]   = bus.w_data_i[j*XLEN +: XLEN];
                    m_busy[id] = 1'b0;
                end
            end
            if (bus.alloc_en_i && bus.alloc_id_i != 0) m_busy[bus.alloc_id_i] = 1'b1;
        end
    endtask

    function automatic bit write_hits(input logic [AW-1:0] id);
        bit hit = 1'b0;
        for (int j = 0; j < NWR; j++)
            if (bus.w_en_i[j] && bus.w_id_i[j*AW +: AW] == id) hit = 1'b1;
        return hit;
    endfunction

    function automatic logic [XLEN-1:0] exp_rd_data(input logic [AW-1:0] id);
        logic [XLEN-1:0] d;
        if (!m_ready || id == 0) return '0;
        d = m_rf[id];
        for (int j = 0; j < NWR; j++)
            if (bus.w_en_i[j] && bus.w_id_i[j*AW +: AW] == id) d = bus.w_data_i[j*XLEN +: XLEN];
        return d;
    endfunction

    function automatic logic exp_rd_busy(input logic [AW-1:0] id);
        if (!m_ready || id == 0) return 1'b0;
        return m_busy[id] && !write_hits(id);
    endfunction

    task automatic check_all(input string tag);
        logic [AW-1:0] id;
        check($sformatf("%s ready", tag), 64'(bus.ready_o), 64'(m_ready));
        check($sformatf("%s busy_o", tag), 64'(bus.busy_o), 64'(m_busy));
        for (int k = 0; k < NRD; k++) begin
            id = bus.rd_id_i[k*AW +: AW];
            check($sformatf("%s rd_data[%0d] id=%0d", tag, k, id),
                  64'(bus.rd_data_o[k*XLEN +: XLEN]), 64'(exp_rd_data(id)));
            check($sformatf("%s rd_busy[%0d] id=%0d", tag, k, id),
                  64'(bus.rd_busy_o[k]), 64'(exp_rd_busy(id)));
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    // Reset for one edge, then walk the sweep checking ready timing exactly.
    task automatic reset_and_sweep(input string tag, input bit noisy);
        rst = 1'b1;
        set_idle('0, '0);
        tick();
        rst = 1'b0;
        for (int c = 1; c <= NREG; c++) begin
            if (noisy)
                set_in(2'($urandom_range(0, 3)), AW'($urandom), $urandom, AW'($urandom),
                       $urandom, 1'($urandom), AW'($urandom), AW'(c - 1), AW'(NREG - c));
            else
                set_idle(AW'(c - 1), AW'(NREG - c));
            #1;
            check($sformatf("%s ready low c=%0d", tag, c), 64'(bus.ready_o), 64'd0);
            check($sformatf("%s sweep rd0 c=%0d", tag, c), 64'(bus.rd_data_o[XLEN-1:0]), 64'd0);
            check($sformatf("%s sweep rb c=%0d", tag, c), 64'(bus.rd_busy_o), 64'd0);
            tick();
        end
        set_idle('0, '0);
        #1;
        check($sformatf("%s ready high", tag), 64'(bus.ready_o), 64'd1);
        check($sformatf("%s busy clear", tag), 64'(bus.busy_o), 64'd0);
    endtask

    function automatic vec_t mk(input logic [1:0] wen, input logic [AW-1:0] wid0,
                                input logic [XLEN-1:0] wd0, input logic [AW-1:0] wid1,
                                input logic [XLEN-1:0] wd1, input logic aen,
                                input logic [AW-1:0] aid, input logic [AW-1:0] rid0,
                                input logic [AW-1:0] rid1, input logic [XLEN-1:0] exp_d0,
                                input logic [XLEN-1:0] exp_d1, input logic [1:0] exp_rb,
                                input logic [NREG-1:0] exp_busy);
        vec_t v;
        v.wen = wen; v.wid0 = wid0; v.wd0 = wd0; v.wid1 = wid1; v.wd1 = wd1;
        v.aen = aen; v.aid = aid; v.rid0 = rid0; v.rid1 = rid1;
        v.exp_d0 = exp_d0; v.exp_d1 = exp_d1; v.exp_rb = exp_rb; v.exp_busy = exp_busy;
        return v;
    endfunction

    initial begin
        set_idle('0, '0);
        // Directed vectors, applied to a freshly cleared file.
        vecs[0]  = mk(2'b01, 5'd5, 32'hDEADBEEF, 5'd0, 32'h0, 1'b0, 5'd0, 5'd5, 5'd0,
                      32'hDEADBEEF, 32'h0, 2'b00, 32'h0);
        vecs[1]  = mk(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd5, 5'd7,
                      32'hDEADBEEF, 32'h0, 2'b00, 32'h0);
        vecs[2]  = mk(2'b11, 5'd7, 32'h11, 5'd7, 32'h22, 1'b0, 5'd0, 5'd7, 5'd5,
                      32'h22, 32'hDEADBEEF, 2'b00, 32'h0);
        vecs[3]  = mk(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd7, 5'd0,
                      32'h22, 32'h0, 2'b00, 32'h0);
        vecs[4]  = mk(2'b01, 5'd0, 32'hFFFFFFFF, 5'd0, 32'h0, 1'b1, 5'd0, 5'd0, 5'd7,
                      32'h0, 32'h22, 2'b00, 32'h0);
        vecs[5]  = mk(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 5'd5,
                      32'h0, 32'hDEADBEEF, 2'b00, 32'h0);
        vecs[6]  = mk(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b1, 5'd3, 5'd3, 5'd0,
                      32'h0, 32'h0, 2'b00, 32'h0);
        vecs[7]  = mk(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd3, 5'd3,
                      32'h0, 32'h0, 2'b11, 32'h8);
        vecs[8]  = mk(2'b01, 5'd3, 32'h33, 5'd0, 32'h0, 1'b1, 5'd3, 5'd3, 5'd0,
                      32'h33, 32'h0, 2'b00, 32'h8);
        vecs[9]  = mk(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd3, 5'd0,
                      32'h33, 32'h0, 2'b01, 32'h8);
        vecs[10] = mk(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b1, 5'd3, 5'd3, 5'd0,
                      32'h33, 32'h0, 2'b01, 32'h8);
        vecs[11] = mk(2'b10, 5'd0, 32'h0, 5'd3, 32'h44, 1'b0, 5'd0, 5'd3, 5'd3,
                      32'h44, 32'h44, 2'b00, 32'h8);
        vecs[12] = mk(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd3, 5'd0,
                      32'h44, 32'h0, 2'b00, 32'h0);

        @(negedge clk);
        // Reset timing and sweep, with write/alloc noise that must be ignored.
        reset_and_sweep("init", 1'b1);
        for (int i = 0; i < NREG / 2; i++) begin
            set_idle(AW'(2 * i), AW'(2 * i + 1));
            #1;
            check($sformatf("clear rd x%0d", 2 * i), 64'(bus.rd_data_o[XLEN-1:0]), 64'd0);
            check($sformatf("clear rd x%0d", 2 * i + 1), 64'(bus.rd_data_o[2*XLEN-1:XLEN]), 64'd0);
            tick();
        end

        for (int i = 0; i < 13; i++) begin
            set_in(vecs[i].wen, vecs[i].wid0, vecs[i].wd0, vecs[i].wid1, vecs[i].wd1,
                   vecs[i].aen, vecs[i].aid, vecs[i].rid0, vecs[i].rid1);
            #1;
            check($sformatf("vec%0d rd0", i), 64'(bus.rd_data_o[XLEN-1:0]), 64'(vecs[i].exp_d0));
            check($sformatf("vec%0d rd1", i), 64'(bus.rd_data_o[2*XLEN-1:XLEN]),
                  64'(vecs[i].exp_d1));
            check($sformatf("vec%0d rd_busy", i), 64'(bus.rd_busy_o), 64'(vecs[i].exp_rb));
            check($sformatf("vec%0d busy_o", i), 64'(bus.busy_o), 64'(vecs[i].exp_busy));
            tick();
        end

        // Randomized traffic with occasional resets, narrow ids to force collisions.
        for (int n = 0; n < 600; n++) begin
            rst = ($urandom_range(0, 149) == 0);
            set_in(2'($urandom_range(0, 3)), AW'($urandom_range(0, 7)), $urandom,
                   AW'($urandom_range(0, 7)), $urandom, 1'($urandom_range(0, 1)),
                   AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7)),
                   AW'($urandom_range(0, 7)));
            #1;
            check_all($sformatf("rand%0d", n));
            tick();
        end
        rst = 1'b0;

        // Reset pulsed again in the middle of a sweep restarts it from the top.
        reset_and_sweep("pre6", 1'b0);
        set_in(2'b01, 5'd9, 32'h55, 5'd0, 32'h0, 1'b1, 5'd4, 5'd0, 5'd0);
        tick();
        set_idle(5'd9, 5'd4);
        #1;
        check("t6 x9 written", 64'(bus.rd_data_o[XLEN-1:0]), 64'h55);
        check("t6 x4 busy", 64'(bus.busy_o), 64'h10);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int c = 0; c < 10; c++) begin
            #1;
            check($sformatf("t6 mid ready c=%0d", c), 64'(bus.ready_o), 64'd0);
            tick();
        end
        reset_and_sweep("t6", 1'b0);
        set_idle(5'd9, 5'd4);
        #1;
        check("t6 x9 cleared", 64'(bus.rd_data_o[XLEN-1:0]), 64'd0);
        check("t6 x4 not busy", 64'(bus.rd_busy_o), 64'd0);
        check_all("t6 final");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
